pd_alu_pipe: RTL and testbench



---
 rtl/pd_alu_pipe.sv | 161 ++++++++++++++++
 tb/tb_pd_alu_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pd_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : pd_alu_pipe
// Purpose  : Execute-stage datapath. A 2-bit-select ALU (add/sub/and/or)
//            feeds a STAGES-deep valid/ready pipeline. The pipeline collapses
//            bubbles, supports a synchronous flush, and reports result flags
//            and an occupancy count.
// Revision : 1.0  initial parametrised release
// ============================================================================
module pd_alu_pipe #(
    parameter int DWIDTH = 32,
    parameter int STAGES = 3,
    parameter int CWIDTH = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_op1,
    input  logic [DWIDTH-1:0] in_op2,
    input  logic [1:0]        in_sel,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_res,
    output logic              out_zero,
    output logic              out_carry,
    output logic [CWIDTH-1:0] occupancy
);

    localparam logic [1:0] c_sel_add = 2'b00;
    localparam logic [1:0] c_sel_sub = 2'b01;
    localparam logic [1:0] c_sel_and = 2'b10;
    localparam logic [1:0] c_sel_or  = 2'b11;

    // ALU result, computed combinationally from the input operands
    logic [DWIDTH:0]   w_sum;
    logic [DWIDTH:0]   w_diff;
    logic [DWIDTH-1:0] w_alu_res;
    logic              w_alu_carry;
    logic              w_alu_zero;

    // Per-stage register set {v, res, zero, carry}; index STAGES-1 is the tail
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [DWIDTH-1:0] res_q [STAGES];
    logic [DWIDTH-1:0] res_d [STAGES];
    logic [STAGES-1:0] zero_q;
    logic [STAGES-1:0] zero_d;
    logic [STAGES-1:0] carry_q;
    logic [STAGES-1:0] carry_d;
    logic [CWIDTH-1:0] occ_q;
    logic [CWIDTH-1:0] occ_d;

    // Handshake control
    logic [STAGES-1:0] w_adv;
    logic              w_accept;

    // ALU: add/sub use a one-bit-wider sum so the MSB gives carry or borrow
    always_comb begin
        w_sum       = {1'b0, in_op1} + {1'b0, in_op2};
        w_diff      = {1'b0, in_op1} - {1'b0, in_op2};
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        unique case (in_sel)
            c_sel_add: begin
                w_alu_res   = w_sum[DWIDTH-1:0];
                w_alu_carry = w_sum[DWIDTH];
            end
            c_sel_sub: begin
                // The wrapped MSB of op1-op2 is set exactly when op1 < op2 (unsigned)
                w_alu_res   = w_diff[DWIDTH-1:0];
                w_alu_carry = w_diff[DWIDTH];
            end
            c_sel_and: w_alu_res = in_op1 & in_op2;
            c_sel_or:  w_alu_res = in_op1 | in_op2;
            default:   w_alu_res = '0;
        endcase
        w_alu_zero = (w_alu_res == '0);
    end

    // Advance chain: a stage passes its entry on when it is valid and its successor is free or itself advancing
    always_comb begin
        w_adv = '0;
        w_adv[STAGES-1] = v_q[STAGES-1] & out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_adv[k] = v_q[k] & (~v_q[k+1] | w_adv[k+1]);
        end
    end

    assign in_ready = ~v_q[0] | w_adv[0];
    // A transaction that arrives together with flush is dropped
    assign w_accept = in_valid & in_ready & ~flush;

    // Next-state for every stage, flush clearing, and the occupancy popcount
    always_comb begin
        v_d     = v_q;
        res_d   = res_q;
        zero_d  = zero_q;
        carry_d = carry_q;

        if (in_ready) begin
            v_d[0] = w_accept;
        end
        if (w_accept) begin
            res_d[0]   = w_alu_res;
            zero_d[0]  = w_alu_zero;
            carry_d[0] = w_alu_carry;
        end

        for (int k = 1; k < STAGES; k++) begin
            if (~v_q[k] | w_adv[k]) begin
                v_d[k] = v_q[k-1];
                // Data moves only with a real entry, so an emptied tail keeps out_res steady
                if (v_q[k-1] & ~flush) begin
                    res_d[k]   = res_q[k-1];
                    zero_d[k]  = zero_q[k-1];
                    carry_d[k] = carry_q[k-1];
                end
            end
        end

        if (flush) begin
            v_d = '0;
        end

        occ_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            occ_d = occ_d + CWIDTH'(v_d[k]);
        end
    end

    // Pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            v_q     <= '0;
            zero_q  <= '0;
            carry_q <= '0;
            occ_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                res_q[k] <= '0;
            end
        end else begin
            v_q     <= v_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            occ_q   <= occ_d;
            for (int k = 0; k < STAGES; k++) begin
                res_q[k] <= res_d[k];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_res   = res_q[STAGES-1];
    assign out_zero  = zero_q[STAGES-1];
    assign out_carry = carry_q[STAGES-1];
    assign occupancy = occ_q;

endmodule
`default_nettype wire

// File: tb/tb_pd_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_pd_alu_pipe
// Purpose  : Self-checking bench for pd_alu_pipe. The driver pushes expected
//            results into a scoreboard queue on acceptance. A separate monitor
//            pops and compares them on every output handshake and also checks
//            occupancy, in_ready and stall stability.
// Revision : 1.0  initial release
// ============================================================================
module tb_pd_alu_pipe;

    localparam int DW = 32;
    localparam int NS = 3;
    localparam int CW = $clog2(NS + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_op1;
    logic [DW-1:0] in_op2;
    logic [1:0]    in_sel;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_res;
    logic          out_zero;
    logic          out_carry;
    logic [CW-1:0] occupancy;

    always #5 clk = ~clk;

    pd_alu_pipe #(.DWIDTH(DW), .STAGES(NS), .CWIDTH(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op1    (in_op1),
        .in_op2    (in_op2),
        .in_sel    (in_sel),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_zero  (out_zero),
        .out_carry (out_carry),
        .occupancy (occupancy)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW+1:0] exp_q[$];      // {carry, zero, res}
    int            in_flight = 0; // entries accepted and neither emitted nor flushed
    bit            emit_seen = 1'b0;
    bit            acc = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_res = '0;
    logic [DW+1:0] mon_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU from the arithmetic definitions
    function automatic logic [DW+1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [1:0] s);
        longint unsigned wide;
        logic [DW-1:0]   r;
        logic            c;
        c = 1'b0;
        case (s)
            2'd0: begin
                wide = longint'(a) + longint'(b);
                r    = a + b;
                c    = (wide > 64'hFFFF_FFFF);
            end
            2'd1: begin
                r = a - b;
                c = (a < b);
            end
            2'd2:    r = a & b;
            default: r = a | b;
        endcase
        return {c, (r == '0), r};
    endfunction

    function automatic logic [DW-1:0] pick();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            2:       return DW'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    // One cycle of stimulus: drive at negedge, decide acceptance, then update the model
    task automatic drive(input bit rst, input bit v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [1:0] s, input bit ordy, input bit fl);
        @(negedge clk);
        reset     = rst;
        in_valid  = v;
        in_op1    = a;
        in_op2    = b;
        in_sel    = s;
        out_ready = ordy;
        flush     = fl;
        #1;
        acc = !rst && v && !fl && ((in_flight < NS) || ordy);
        if (acc) exp_q.push_back(model(a, b, s));
        #3;
        if (rst || fl) begin
            exp_q.delete();
            in_flight = 0;
        end else begin
            in_flight = in_flight + int'(acc) - int'(emit_seen);
        end
    endtask

    task automatic idle(input bit ordy);
        drive(1'b0, 1'b0, '0, '0, 2'd0, ordy, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4 * NS + 10) begin
            idle(1'b1);
            n++;
        end
        idle(1'b1);
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_occupancy", occupancy, 0);
    endtask

    // Monitor: compare outputs against the scoreboard away from the clock edge
    always @(negedge clk) begin
        #2;
        emit_seen = 1'b0;
        if (!reset) begin
            chk("occupancy", occupancy, in_flight);
            chk("in_ready", in_ready, ((in_flight < NS) || out_ready));
            if (prev_stall) chk("stall_hold", {out_valid, out_res}, {1'b1, prev_res});
            if (out_valid && out_ready) begin
                emit_seen = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {out_carry, out_zero, out_res}, 64'hDEAD_0000_0000);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("result", {out_carry, out_zero, out_res}, mon_exp);
                end
            end
        end
        prev_stall = !reset && !flush && out_valid && !out_ready;
        prev_res   = out_res;
    end

    // Watchdog so the run always terminates
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] ba [5];
    logic [DW-1:0] bb [5];
    logic [1:0]    bs [5];

    // Directed scenarios followed by randomized traffic
    initial begin
        int idx;
        int guard;
        reset = 1'b1; in_valid = 1'b0; in_op1 = '0; in_op2 = '0; in_sel = '0;
        flush = 1'b0; out_ready = 1'b0;

        // Reset then idle
        drive(1'b1, 1'b0, '0, '0, 2'd0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 2'd0, 1'b1, 1'b0);
        idle(1'b1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_res", out_res, 0);
        chk("rst_out_zero", out_zero, 0);
        chk("rst_out_carry", out_carry, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_in_ready", in_ready, 1);

        // Streaming with latency checks
        drive(1'b0, 1'b1, 32'd5, 32'd7, 2'd0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 32'd3, 32'd5, 2'd1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 32'hF0F0, 32'h0FF0, 2'd2, 1'b1, 1'b0);
        chk("latency_early", out_valid, 0);
        drive(1'b0, 1'b1, 32'h1, 32'h2, 2'd3, 1'b1, 1'b0);
        chk("latency_first", {out_valid, out_carry, out_zero, out_res}, {1'b1, 1'b0, 1'b0, 32'd12});
        drain();

        // Flag corners
        drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 2'd0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 32'd9, 32'd9, 2'd1, 1'b1, 1'b0);
        drain();

        // Backpressure: five transactions against a stalled output
        for (int i = 0; i < 5; i++) begin
            ba[i] = pick(); bb[i] = pick(); bs[i] = 2'($urandom_range(0, 3));
        end
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, idx < 5, ba[idx % 5], bb[idx % 5], bs[idx % 5], 1'b0, 1'b0);
            if (acc) idx++;
        end
        chk("bp_occupancy", occupancy, 3);
        chk("bp_in_ready", in_ready, 0);
        guard = 0;
        while (idx < 5 && guard < 20) begin
            drive(1'b0, 1'b1, ba[idx], bb[idx], bs[idx], 1'b1, 1'b0);
            if (acc) idx++;
            guard++;
        end
        drain();

        // Bubble collapse
        drive(1'b0, 1'b1, 32'd100, 32'd1, 2'd0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        drive(1'b0, 1'b1, 32'd200, 32'd2, 2'd1, 1'b0, 1'b0);
        idle(1'b0);
        chk("bubble_occupancy", occupancy, 2);
        chk("bubble_in_ready", in_ready, 1);
        chk("bubble_tail", {out_valid, out_res}, {1'b1, 32'd101});
        idle(1'b1);
        idle(1'b0);
        chk("bubble_packed", {out_valid, out_res}, {1'b1, 32'd198});
        drain();

        // Flush with a full pipe and a valid input
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, pick(), pick(), 2'($urandom_range(0, 3)), 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'd77, 32'd1, 2'd0, 1'b1, 1'b1);
        idle(1'b0);
        chk("flush_occupancy", occupancy, 0);
        chk("flush_out_valid", out_valid, 0);
        drain();

        // Reset mid-flight
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 32'h55, 32'h22, 2'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 32'd77, 32'd1, 2'd0, 1'b1, 1'b0);
        idle(1'b0);
        chk("rstmid_occupancy", occupancy, 0);
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_out_res", out_res, 0);
        chk("rstmid_in_ready", in_ready, 1);
        drain();

        // Randomized traffic with occasional flush
        for (int c = 0; c < 400; c++) begin
            drive(1'b0, $urandom_range(0, 3) != 0, pick(), pick(), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
